// File: rtl/pwm_duty_scheduler.sv
// rtl/pwm_duty_scheduler.sv - batched per-channel PWM duty commit on period TICK (soft ramp option: PWM_SOFT_RAMP_EN)
module pwm_duty_scheduler #(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int CHW = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TICK,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [CHW-1:0]    CMD_CH,
    input  logic [DW-1:0]     CMD_DUTY,
    output logic [NCH*DW-1:0] DUTY,
    output logic              COMMIT,
    output logic              BUSY
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [DW-1:0]  shadow     [NCH];
    logic [DW-1:0]  target     [NCH];
    logic [DW-1:0]  target_nxt [NCH];
    logic [DW-1:0]  active     [NCH];
    logic [NCH-1:0] pend;
    logic           xfer;

    assign CMD_READY = !RST && (state != APPLY);
    assign xfer      = CMD_VALID && CMD_READY;
    assign COMMIT    = (state == APPLY);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = PENDING;
            PENDING: if (TICK) state_nxt = APPLY;
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Only channels written since the last commit pick up their shadow.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            target_nxt[k] = (COMMIT && pend[k]) ? shadow[k] : target[k];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            pend  <= '0;
            for (int k = 0; k < NCH; k++) begin
                shadow[k] <= '0;
                target[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            for (int k = 0; k < NCH; k++) begin
                target[k] <= target_nxt[k];
            end
            if (COMMIT) begin
                pend <= '0;
            end
            if (xfer) begin
                shadow[CMD_CH] <= CMD_DUTY;
                pend[CMD_CH]   <= 1'b1;
            end
`ifdef PWM_SOFT_RAMP_EN
            // One LSB per period toward target; equality stops the ramp, so it never overshoots.
            if (TICK) begin
                for (int k = 0; k < NCH; k++) begin
                    if (active[k] < target[k]) begin
                        active[k] <= active[k] + DW'(1);
                    end else if (active[k] > target[k]) begin
                        active[k] <= active[k] - DW'(1);
                    end
                end
            end
`else
            // Loading from the post-commit value lands new duty the cycle after COMMIT.
            for (int k = 0; k < NCH; k++) begin
                active[k] <= target_nxt[k];
            end
`endif
        end
    end

    always_comb begin
        DUTY = '0;
        BUSY = |pend;
        for (int k = 0; k < NCH; k++) begin
            DUTY[k*DW +: DW] = active[k];
            if (active[k] != target[k]) begin
                BUSY = 1'b1;
            end
        end
    end

endmodule
